// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for load-use stalls, taken-branch
//            flushes and memory freezes, with saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk_HZ,
    input  logic             rst_HZ,
    input  logic [4:0]       Rs1_addr_ID,
    input  logic [4:0]       Rs2_addr_ID,
    input  logic             Rs1_used_ID,
    input  logic             Rs2_used_ID,
    input  logic [4:0]       Rd_addr_EX,
    input  logic             RegWrite_EX,
    input  logic [1:0]       MemtoReg_EX,
    input  logic             Taken_EX,
    input  logic             Mem_busy,
    output logic             en_PC,
    output logic             en_IFID,
    output logic             en_IDEX,
    output logic             en_EXMEM,
    output logic             en_MEMWB,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic [1:0]       state_HZ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    localparam logic [2:0]       c_STALL_INIT = 3'(LOAD_STALL_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    state_t           saved_q, saved_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    logic   w_load_use;
    state_t w_mode;
    logic   w_stall_inc;
    logic   w_flush_inc;
    logic   w_freeze_inc;

    assign w_load_use = RegWrite_EX && (MemtoReg_EX == 2'b01) && (Rd_addr_EX != 5'd0) &&
                        ((Rs1_used_ID && (Rs1_addr_ID == Rd_addr_EX)) ||
                         (Rs2_used_ID && (Rs2_addr_ID == Rd_addr_EX)));

    // While frozen, behave as the state we were frozen out of.
    assign w_mode = (state_q == ST_FREEZE) ? saved_q : state_q;

    always_comb begin
        state_d      = state_q;
        saved_d      = saved_q;
        rem_d        = rem_q;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_freeze_inc = 1'b0;
        en_PC        = 1'b1;
        en_IFID      = 1'b1;
        en_IDEX      = 1'b1;
        en_EXMEM     = 1'b1;
        en_MEMWB     = 1'b1;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;

        if (Mem_busy) begin
            en_PC        = 1'b0;
            en_IFID      = 1'b0;
            en_IDEX      = 1'b0;
            en_EXMEM     = 1'b0;
            en_MEMWB     = 1'b0;
            state_d      = ST_FREEZE;
            saved_d      = w_mode;
            w_freeze_inc = 1'b1;
        end else if (w_mode == ST_STALL) begin
            // EX holds a bubble here, so a taken branch cannot be real.
            en_PC       = 1'b0;
            en_IFID     = 1'b0;
            flush_IDEX  = 1'b1;
            w_stall_inc = 1'b1;
            rem_d       = rem_q - 3'd1;
            state_d     = (rem_d == 3'd0) ? ST_RUN : ST_STALL;
        end else if (Taken_EX) begin
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            w_flush_inc = 1'b1;
            state_d     = ST_RUN;
        end else if (w_load_use) begin
            en_PC       = 1'b0;
            en_IFID     = 1'b0;
            flush_IDEX  = 1'b1;
            w_stall_inc = 1'b1;
            rem_d       = c_STALL_INIT;
            state_d     = (c_STALL_INIT != 3'd0) ? ST_STALL : ST_RUN;
        end else begin
            state_d = ST_RUN;
        end

        if (rst_HZ) begin
            en_PC      = 1'b0;
            en_IFID    = 1'b0;
            en_IDEX    = 1'b0;
            en_EXMEM   = 1'b0;
            en_MEMWB   = 1'b0;
            flush_IFID = 1'b0;
            flush_IDEX = 1'b0;
        end
    end

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (w_stall_inc && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + c_CNT_ONE;
        end
        if (w_flush_inc && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + c_CNT_ONE;
        end
        if (w_freeze_inc && !(&freeze_cnt_q)) begin
            freeze_cnt_d = freeze_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_HZ or posedge rst_HZ) begin
        if (rst_HZ) begin
            state_q      <= ST_RUN;
            saved_q      <= ST_RUN;
            rem_q        <= 3'd0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            saved_q      <= saved_d;
            rem_q        <= rem_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign state_HZ   = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed vector bench for hazard_ctrl in three parameter builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_HZ;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, rw, tk, mb;
    logic [1:0] mtr;

    // a: LOAD_STALL_CYC=1; b: LOAD_STALL_CYC=3; c: LOAD_STALL_CYC=3, CNT_W=4
    wire [4:0]  a_en, b_en, c_en;
    wire [1:0]  a_fl, b_fl, c_fl;
    wire [1:0]  a_st, b_st, c_st;
    wire [15:0] a_sc, a_fc, a_zc, b_sc, b_fc, b_zc;
    wire [3:0]  c_sc, c_fc, c_zc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYC(1), .CNT_W(16)) u_a (
        .clk_HZ(clk), .rst_HZ(rst_HZ),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(u1), .Rs2_used_ID(u2),
        .Rd_addr_EX(rd), .RegWrite_EX(rw), .MemtoReg_EX(mtr), .Taken_EX(tk), .Mem_busy(mb),
        .en_PC(a_en[4]), .en_IFID(a_en[3]), .en_IDEX(a_en[2]), .en_EXMEM(a_en[1]), .en_MEMWB(a_en[0]),
        .flush_IFID(a_fl[1]), .flush_IDEX(a_fl[0]), .state_HZ(a_st),
        .stall_cnt(a_sc), .flush_cnt(a_fc), .freeze_cnt(a_zc)
    );

    hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(16)) u_b (
        .clk_HZ(clk), .rst_HZ(rst_HZ),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(u1), .Rs2_used_ID(u2),
        .Rd_addr_EX(rd), .RegWrite_EX(rw), .MemtoReg_EX(mtr), .Taken_EX(tk), .Mem_busy(mb),
        .en_PC(b_en[4]), .en_IFID(b_en[3]), .en_IDEX(b_en[2]), .en_EXMEM(b_en[1]), .en_MEMWB(b_en[0]),
        .flush_IFID(b_fl[1]), .flush_IDEX(b_fl[0]), .state_HZ(b_st),
        .stall_cnt(b_sc), .flush_cnt(b_fc), .freeze_cnt(b_zc)
    );

    hazard_ctrl #(.LOAD_STALL_CYC(3), .CNT_W(4)) u_c (
        .clk_HZ(clk), .rst_HZ(rst_HZ),
        .Rs1_addr_ID(rs1), .Rs2_addr_ID(rs2), .Rs1_used_ID(u1), .Rs2_used_ID(u2),
        .Rd_addr_EX(rd), .RegWrite_EX(rw), .MemtoReg_EX(mtr), .Taken_EX(tk), .Mem_busy(mb),
        .en_PC(c_en[4]), .en_IFID(c_en[3]), .en_IDEX(c_en[2]), .en_EXMEM(c_en[1]), .en_MEMWB(c_en[0]),
        .flush_IFID(c_fl[1]), .flush_IDEX(c_fl[0]), .state_HZ(c_st),
        .stall_cnt(c_sc), .flush_cnt(c_fc), .freeze_cnt(c_zc)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic [1:0] mtr;
        logic       tk;
        logic       mb;
        logic [4:0] en;
        logic [1:0] fl;
        logic [1:0] st;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; rd = v.rd;
        rw = v.rw; mtr = v.mtr; tk = v.tk; mb = v.mb;
    endtask

    task automatic idle();
        rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0; rd = 5'd0;
        rw = 1'b0; mtr = 2'b00; tk = 1'b0; mb = 1'b0;
    endtask

    task automatic load_use5();
        idle();
        rs1 = 5'd5; u1 = 1'b1; rd = 5'd5; rw = 1'b1; mtr = 2'b01;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_HZ = 1'b1;
        tick();
        rst_HZ = 1'b0;
    endtask

    initial begin
        int exp_pc[6];
        int exp_mw[6];
        int exp_st[6];
        int zeros;

        //            rs1   rs2   u1    u2    rd    rw    mtr    tk    mb    en        fl     st
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 5'b00111, 2'b01, 2'd0};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[4]  = '{5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[5]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 5'b00111, 2'b01, 2'd0};
        vecs[6]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 2'b01, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b10, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b0, 5'b11111, 2'b11, 2'd0};
        vecs[9]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b1, 5'b00000, 2'b00, 2'd0};
        vecs[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 5'b00000, 2'b00, 2'd2};
        vecs[11] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 5'b00111, 2'b01, 2'd2};
        vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 5'b11111, 2'b00, 2'd0};
        vecs[13] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 5'b11111, 2'b11, 2'd0};

        // Reset state, including outputs held inactive while reset is high
        idle();
        rst_HZ = 1'b1;
        @(negedge clk);
        chk("rst_en", 32'(a_en), 32'h0);
        chk("rst_fl", 32'(a_fl), 32'h0);
        chk("rst_st", 32'(a_st), 32'h0);
        chk("rst_cnts", {a_sc, a_fc} | 32'(a_zc), 32'h0);
        tick();
        rst_HZ = 1'b0;
        @(negedge clk);
        chk("post_rst_en", 32'(a_en), 32'h1f);
        tick();

        // Single-cycle vector table on the LOAD_STALL_CYC=1 build
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_en", i), 32'(a_en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_fl", i), 32'(a_fl), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_st", i), 32'(a_st), 32'(vecs[i].st));
            tick();
        end
        chk("tbl_stall_cnt", 32'(a_sc), 32'd3);
        chk("tbl_flush_cnt", 32'(a_fc), 32'd2);
        chk("tbl_freeze_cnt", 32'(a_zc), 32'd2);

        // Multi-cycle load-use stall: one cycle for a, three for b
        do_reset();
        load_use5();
        @(negedge clk);
        chk("ls_a_en", 32'(a_en), 32'h07);
        chk("ls_b_en", 32'(b_en), 32'h07);
        chk("ls_b_st0", 32'(b_st), 32'd0);
        tick();
        idle();
        exp_st = '{1, 1, 0, 0, 0, 0};
        exp_pc = '{0, 0, 1, 1, 1, 1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ls_b_st%0d", k + 1), 32'(b_st), 32'(exp_st[k]));
            chk($sformatf("ls_b_pc%0d", k + 1), 32'(b_en[4]), 32'(exp_pc[k]));
            chk($sformatf("ls_a_en%0d", k + 1), 32'(a_en), 32'h1f);
            tick();
        end
        chk("ls_a_stall_cnt", 32'(a_sc), 32'd1);
        chk("ls_b_stall_cnt", 32'(b_sc), 32'd3);

        // Taken branch beats concurrent load-use
        do_reset();
        load_use5();
        tk = 1'b1;
        @(negedge clk);
        chk("tk_b_en", 32'(b_en), 32'h1f);
        chk("tk_b_fl", 32'(b_fl), 32'h3);
        tick();
        idle();
        @(negedge clk);
        chk("tk_b_st", 32'(b_st), 32'd0);
        chk("tk_b_flush_cnt", 32'(b_fc), 32'd1);
        chk("tk_b_stall_cnt", 32'(b_sc), 32'd0);
        tick();

        // Freeze for two cycles during the second stall cycle
        do_reset();
        exp_pc = '{0, 0, 0, 0, 0, 1};
        exp_mw = '{1, 0, 0, 1, 1, 1};
        exp_st = '{0, 1, 2, 2, 1, 0};
        zeros  = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) load_use5();
            else idle();
            mb = (k == 1 || k == 2);
            @(negedge clk);
            chk($sformatf("fz_pc%0d", k), 32'(b_en[4]), 32'(exp_pc[k]));
            chk($sformatf("fz_mw%0d", k), 32'(b_en[0]), 32'(exp_mw[k]));
            chk($sformatf("fz_st%0d", k), 32'(b_st), 32'(exp_st[k]));
            if (b_en[4] == 1'b0) zeros++;
            tick();
        end
        idle();
        chk("fz_pc_zero_cycles", 32'(zeros), 32'd5);
        chk("fz_stall_cnt", 32'(b_sc), 32'd3);
        chk("fz_freeze_cnt", 32'(b_zc), 32'd2);

        // Saturation of a 4-bit flush counter
        do_reset();
        tk = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        chk("sat_c_fc15", 32'(c_fc), 32'hf);
        tick();
        chk("sat_c_fc16", 32'(c_fc), 32'hf);

        // Asynchronous reset while stalled
        load_use5();
        tick();
        idle();
        chk("ar_c_st_stall", 32'(c_st), 32'd1);
        #2;
        rst_HZ = 1'b1;
        #1;
        chk("ar_c_st", 32'(c_st), 32'd0);
        chk("ar_c_cnts", {20'd0, c_sc, c_fc, c_zc}, 32'h0);
        chk("ar_c_en", 32'(c_en), 32'h0);
        tick();
        rst_HZ = 1'b0;
        @(negedge clk);
        chk("ar_c_st_after", 32'(c_st), 32'd0);
        chk("ar_c_en_after", 32'(c_en), 32'h1f);
        chk("ar_c_fl_after", 32'(c_fl), 32'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
